pio_out_shifter: RTL and testbench

- Output shift register (OSR) stage of a PIO state machine. Sits directly downstream of the clock divider and consumes its `penable` strobe.
- Shifts 1–32 bits out of a 32-bit register once per enabled `penable` tick, in either direction, and presents them right-justified to the pin-mapping logic.
- Refills itself from the TX FIFO through a valid/ready pop handshake (autopull) when the shift count reaches a programmable threshold.

---
 rtl/pio_out_shifter_if.sv | 30 +++
 rtl/pio_out_shifter.sv | 119 +++++++++++
 tb/tb_pio_out_shifter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pio_out_shifter_if.sv
// ---------------------------------------------------------------------------
// pio_out_shifter_if
// Pop handshake between the TX FIFO head and the PIO output shift register.
//   fifo_data  : head word of the TX FIFO
//   fifo_valid : FIFO is non-empty
//   fifo_ready : pop strobe from the consumer; a pop happens on a clock edge
//                where fifo_ready && fifo_valid
// Modports:
//   master : FIFO side (drives data/valid, observes ready)
//   slave  : shifter side (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface pio_out_shifter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_valid;
  logic              fifo_ready;

  modport master (
    output fifo_data,
    output fifo_valid,
    input  fifo_ready
  );

  modport slave (
    input  fifo_data,
    input  fifo_valid,
    output fifo_ready
  );
endinterface

// File: rtl/pio_out_shifter.sv
// ---------------------------------------------------------------------------
// pio_out_shifter
// Output shift register (OSR) stage of a PIO state machine. On each enabled
// penable tick it shifts 1..32 bits out of a 32-bit register (LSB-first or
// MSB-first) and presents them right-justified on pins_out. When autopull is
// on and the shift count has reached the pull threshold it refills from the
// TX FIFO instead of shifting.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   penable      : one shift opportunity per tick (from the clock divider)
//   enable       : state machine enabled; all state is held when low
//   restart      : synchronous clear of OSR state
//   shift_right  : 1 = LSB first, 0 = MSB first
//   out_count    : bits per shift, 0 encodes 32
//   autopull     : enable automatic refill from the FIFO
//   pull_thresh  : refill threshold, 0 encodes 32
//   fifo         : TX FIFO pop handshake (slave side)
//   pins_out     : last shifted-out bits, right-justified, zero-extended
//   pins_valid   : one-cycle pulse when pins_out is updated
//   osr_count    : bits shifted since last load (0..32)
//   stall        : a penable tick was dropped because a refill is pending
// ---------------------------------------------------------------------------
module pio_out_shifter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              penable,
  input  logic              enable,
  input  logic              restart,
  input  logic              shift_right,
  input  logic [4:0]        out_count,
  input  logic              autopull,
  input  logic [4:0]        pull_thresh,
  pio_out_shifter_if.slave  fifo,
  output logic [DATA_W-1:0] pins_out,
  output logic              pins_valid,
  output logic [5:0]        osr_count,
  output logic              stall
);

  logic [DATA_W-1:0] osr;
  logic [5:0]        count;

  logic [5:0]        shift_n;
  logic [5:0]        thresh;
  logic              need;
  logic              do_pop;
  logic              do_shift;
  logic [DATA_W-1:0] shift_pins;
  logic [DATA_W-1:0] shift_osr;
  logic [6:0]        count_sum;
  logic [5:0]        count_after_shift;

  // Decode the 0-means-32 config fields and work out whether this cycle is a
  // refill (pop) or a shift. need is forced low during reset so the pop
  // strobe and stall never leak out while the block is being cleared.
  always_comb begin
    shift_n  = (out_count == 5'd0)   ? 6'd32 : {1'b0, out_count};
    thresh   = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
    need     = !reset && enable && autopull && !restart && (count >= thresh);
    do_pop   = need && fifo.fifo_valid;
    do_shift = penable && enable && !restart && !need;
  end

  assign fifo.fifo_ready = need;
  assign stall           = !reset && penable && need;
  assign osr_count       = count;

  // Shift datapath. A full 32-bit shift is handled as its own case so the
  // register is cleared explicitly instead of relying on shift-by-width.
  always_comb begin
    shift_pins = '0;
    shift_osr  = '0;
    if (out_count == 5'd0) begin
      shift_pins = osr;
      shift_osr  = '0;
    end else if (shift_right) begin
      shift_pins = osr & ~({DATA_W{1'b1}} << out_count);
      shift_osr  = osr >> out_count;
    end else begin
      shift_pins = osr >> (6'd32 - shift_n);
      shift_osr  = osr << out_count;
    end
  end

  // Shift count saturates at 32 so shifting past empty (autopull off) keeps
  // reporting a full count and keeps the refill condition satisfied.
  always_comb begin
    count_sum         = {1'b0, count} + {1'b0, shift_n};
    count_after_shift = (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];
  end

  // State update: restart wins over everything, then a pop, then a shift.
  // Pop and shift are mutually exclusive because a shift requires !need.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      osr        <= '0;
      count      <= 6'd32;
      pins_out   <= '0;
      pins_valid <= 1'b0;
    end else begin
      pins_valid <= 1'b0;
      if (restart) begin
        osr   <= '0;
        count <= 6'd32;
      end else if (do_pop) begin
        osr   <= fifo.fifo_data;
        count <= 6'd0;
      end else if (do_shift) begin
        osr        <= shift_osr;
        count      <= count_after_shift;
        pins_out   <= shift_pins;
        pins_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pio_out_shifter.sv
// ---------------------------------------------------------------------------
// tb_pio_out_shifter
// Directed bench for pio_out_shifter. Every non-stalled shift tick pushes the
// expected pins_out/osr_count pair to a queue; a monitor pops and compares it
// when pins_valid pulses. Any pins_valid pulse with nothing expected is an
// error, which also covers stalled, restarted and disabled ticks.
// ---------------------------------------------------------------------------
module tb_pio_out_shifter;

  typedef struct {
    logic [31:0] pins;
    logic [5:0]  cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        penable;
  logic        enable;
  logic        restart;
  logic        shift_right;
  logic [4:0]  out_count;
  logic        autopull;
  logic [4:0]  pull_thresh;
  logic [31:0] pins_out;
  logic        pins_valid;
  logic [5:0]  osr_count;
  logic        stall;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  pio_out_shifter_if fifo_bus ();

  pio_out_shifter dut (
    .clk         (clk),
    .reset       (reset),
    .penable     (penable),
    .enable      (enable),
    .restart     (restart),
    .shift_right (shift_right),
    .out_count   (out_count),
    .autopull    (autopull),
    .pull_thresh (pull_thresh),
    .fifo        (fifo_bus.slave),
    .pins_out    (pins_out),
    .pins_valid  (pins_valid),
    .osr_count   (osr_count),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One penable tick. Combinational outputs are checked mid-cycle; a
  // non-stalled tick queues the expected shift result.
  task automatic tick(input logic exp_stall, input logic [31:0] exp_pins, input logic [5:0] exp_cnt);
    exp_t e;
    penable = 1'b1;
    #1;
    check("stall", stall, exp_stall);
    if (!exp_stall) begin
      e.pins = exp_pins;
      e.cnt  = exp_cnt;
      exp_q.push_back(e);
    end
    step();
    penable = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && pins_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pins_valid", pins_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("pins_out", pins_out, e.pins);
        check("osr_count_shift", osr_count, e.cnt);
      end
    end
  end

  initial begin
    reset               = 1'b1;
    penable             = 1'b1;
    enable              = 1'b1;
    restart             = 1'b0;
    shift_right         = 1'b1;
    out_count           = 5'd8;
    autopull            = 1'b1;
    pull_thresh         = 5'd0;
    fifo_bus.fifo_data  = 32'hA5A5_1234;
    fifo_bus.fifo_valid = 1'b1;

    // Reset state, with inputs that would otherwise request a pop and stall
    #2;
    check("rst_pins_out", pins_out, 32'h0);
    check("rst_pins_valid", pins_valid, 1'b0);
    check("rst_osr_count", osr_count, 6'd32);
    check("rst_fifo_ready", fifo_bus.fifo_ready, 1'b0);
    check("rst_stall", stall, 1'b0);
    penable = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Byte-wise right shift with autopull at threshold 32
    #1;
    check("t1_fifo_ready", fifo_bus.fifo_ready, 1'b1);
    step();
    check("t1_count_loaded", osr_count, 6'd0);
    fifo_bus.fifo_valid = 1'b0;
    fifo_bus.fifo_data  = 32'h1122_3344;
    #1;
    check("t1_no_ready", fifo_bus.fifo_ready, 1'b0);
    tick(1'b0, 32'h0000_0034, 6'd8);
    tick(1'b0, 32'h0000_0012, 6'd16);
    tick(1'b0, 32'h0000_00A5, 6'd24);
    tick(1'b0, 32'h0000_00A5, 6'd32);
    fifo_bus.fifo_valid = 1'b1;
    #1;
    check("t1_refill_ready", fifo_bus.fifo_ready, 1'b1);
    tick(1'b1, 32'h0, 6'd0);
    check("t1_refill_count", osr_count, 6'd0);
    fifo_bus.fifo_valid = 1'b0;
    tick(1'b0, 32'h0000_0044, 6'd8);

    // Restart colliding with penable and a valid FIFO word
    fifo_bus.fifo_valid = 1'b1;
    fifo_bus.fifo_data  = 32'h8000_0001;
    restart = 1'b1;
    penable = 1'b1;
    #1;
    check("rs_fifo_ready", fifo_bus.fifo_ready, 1'b0);
    step();
    restart = 1'b0;
    penable = 1'b0;
    check("rs_count", osr_count, 6'd32);

    // Load 0x8000_0001, then MSB-first nibbles with autopull off
    #1;
    check("t2_fifo_ready", fifo_bus.fifo_ready, 1'b1);
    step();
    autopull            = 1'b0;
    fifo_bus.fifo_valid = 1'b0;
    shift_right         = 1'b0;
    out_count           = 5'd4;
    tick(1'b0, 32'h8, 6'd4);
    for (int i = 2; i <= 7; i++) tick(1'b0, 32'h0, 6'(4 * i));
    tick(1'b0, 32'h1, 6'd32);
    tick(1'b0, 32'h0, 6'd32);
    tick(1'b0, 32'h0, 6'd32);

    // Full-word shifts, right then left, threshold 32
    autopull            = 1'b1;
    out_count           = 5'd0;
    shift_right         = 1'b1;
    fifo_bus.fifo_valid = 1'b1;
    fifo_bus.fifo_data  = 32'hDEAD_BEEF;
    tick(1'b1, 32'h0, 6'd0);
    fifo_bus.fifo_data  = 32'h0123_4567;
    tick(1'b0, 32'hDEAD_BEEF, 6'd32);
    shift_right = 1'b0;
    tick(1'b1, 32'h0, 6'd0);
    fifo_bus.fifo_valid = 1'b0;
    tick(1'b0, 32'h0123_4567, 6'd32);

    // Empty FIFO with a refill pending: every tick stalls
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_fifo_ready", fifo_bus.fifo_ready, 1'b1);
      tick(1'b1, 32'h0, 6'd0);
      check("t4_count", osr_count, 6'd32);
    end

    // Disabled: no pop, no stall, no shift
    enable              = 1'b0;
    fifo_bus.fifo_valid = 1'b1;
    fifo_bus.fifo_data  = 32'h0000_00C3;
    penable             = 1'b1;
    #1;
    check("dis_fifo_ready", fifo_bus.fifo_ready, 1'b0);
    check("dis_stall", stall, 1'b0);
    step();
    penable = 1'b0;
    check("dis_count", osr_count, 6'd32);
    enable = 1'b1;

    // Asynchronous reset while a shift result is being presented
    shift_right = 1'b1;
    out_count   = 5'd8;
    step();
    check("t6_count_loaded", osr_count, 6'd0);
    fifo_bus.fifo_valid = 1'b0;
    tick(1'b0, 32'h0000_00C3, 6'd8);
    @(negedge clk);
    #1;
    check("t6_pre_reset_valid", pins_valid, 1'b1);
    reset   = 1'b1;
    penable = 1'b1;
    #1;
    check("t6_pins_out", pins_out, 32'h0);
    check("t6_pins_valid", pins_valid, 1'b0);
    check("t6_osr_count", osr_count, 6'd32);
    check("t6_fifo_ready", fifo_bus.fifo_ready, 1'b0);
    check("t6_stall", stall, 1'b0);
    step();
    penable = 1'b0;
    reset   = 1'b0;
    step();
    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
